// File: rtl/bank_command_issuer.sv
// Single-bank DRAM command issuer: open-page row management with tRCD/tRP/tRAS
// timing and periodic refresh, driving a registered cs/ras/cas/we command bus.
module bank_command_issuer #(
  parameter int unsigned COL_BITS = 10,
  parameter int unsigned T_RCD    = 3,
  parameter int unsigned T_RP     = 3,
  parameter int unsigned T_RAS    = 8,
  parameter int unsigned T_REFI   = 200,
  parameter int unsigned T_RFC    = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic        req_write,
  input  logic [31:0] req_id,
  output logic        cmd_fire,
  output logic        cs,
  output logic        ras,
  output logic        cas,
  output logic        we,
  output logic [31:0] cmd_addr,
  output logic [31:0] cmd_data,
  output logic [31:0] cmd_id,
  output logic [63:0] global_cycle
);

  localparam int unsigned ROW_BITS = 32 - COL_BITS;
  localparam int unsigned WAIT_MAX = (T_RCD > T_RP) ? ((T_RCD > T_RFC) ? T_RCD : T_RFC)
                                                    : ((T_RP > T_RFC) ? T_RP : T_RFC);
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int unsigned RAS_W    = $clog2(T_RAS + 1);
  localparam int unsigned REFI_W   = $clog2(T_REFI + 1);
  // Wait states are entered one cycle after the command, so they hold T-1 cycles.
  localparam int unsigned RCD_LOAD = (T_RCD > 1) ? T_RCD - 2 : 0;
  localparam int unsigned RP_LOAD  = (T_RP > 1) ? T_RP - 2 : 0;
  localparam int unsigned RFC_LOAD = (T_RFC > 1) ? T_RFC - 2 : 0;

  localparam logic [3:0] CMD_NOP = 4'b1111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT, S_RW, S_REF, S_REF_WAIT
  } state_t;

  state_t              state, state_d;
  logic [WAIT_W-1:0]   wait_cnt, wait_d;
  logic                pre_ref, pre_ref_d;
  logic                accept_c, ref_done_c, pre_fire_c;
  logic [RAS_W-1:0]    tras, tras_d;
  logic [REFI_W-1:0]   refi;
  logic                ref_pending;
  logic                row_open;
  logic [ROW_BITS-1:0] open_row;
  logic [31:0]         lat_addr, lat_data, lat_id;
  logic                lat_write;
  logic [31:0]         lat_addr_d, lat_data_d, lat_id_d;
  logic                lat_write_d;
  logic [3:0]          cmd_d;
  logic [31:0]         cmd_addr_d, cmd_data_d, cmd_id_d;

  assign req_ready   = reset && (state == S_IDLE) && !ref_pending;
  assign lat_addr_d  = accept_c ? req_addr  : lat_addr;
  assign lat_data_d  = accept_c ? req_data  : lat_data;
  assign lat_id_d    = accept_c ? req_id    : lat_id;
  assign lat_write_d = accept_c ? req_write : lat_write;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      pre_ref  <= 1'b0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_d;
      pre_ref  <= pre_ref_d;
    end
  end

  // Next-state logic: request/refresh arbitration and timing countdowns.
  always_comb begin
    state_d    = state;
    wait_d     = wait_cnt;
    pre_ref_d  = pre_ref;
    accept_c   = 1'b0;
    ref_done_c = 1'b0;
    pre_fire_c = (state == S_PRE) && (tras == '0);
    if (state == S_ACT)      tras_d = RAS_W'(T_RAS - 1);
    else if (tras != '0)     tras_d = tras - RAS_W'(1);
    else                     tras_d = tras;
    case (state)
      S_IDLE: begin
        if (ref_pending) begin
          if (row_open) begin
            state_d   = S_PRE;
            pre_ref_d = 1'b1;
          end else begin
            state_d = S_REF;
          end
        end else if (req_valid) begin
          accept_c  = 1'b1;
          pre_ref_d = 1'b0;
          if (!row_open)                               state_d = S_ACT;
          else if (req_addr[31:COL_BITS] == open_row)  state_d = S_RW;
          else                                         state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (pre_fire_c) begin
          if (T_RP == 1) begin
            state_d = pre_ref ? S_REF : S_ACT;
          end else begin
            state_d = S_PRE_WAIT;
            wait_d  = WAIT_W'(RP_LOAD);
          end
        end
      end
      S_PRE_WAIT: begin
        if (wait_cnt == '0) state_d = pre_ref ? S_REF : S_ACT;
        else                wait_d  = wait_cnt - WAIT_W'(1);
      end
      S_ACT: begin
        if (T_RCD == 1) begin
          state_d = S_RW;
        end else begin
          state_d = S_ACT_WAIT;
          wait_d  = WAIT_W'(RCD_LOAD);
        end
      end
      S_ACT_WAIT: begin
        if (wait_cnt == '0) state_d = S_RW;
        else                wait_d  = wait_cnt - WAIT_W'(1);
      end
      S_RW: state_d = S_IDLE;
      S_REF: begin
        if (T_RFC == 1) begin
          state_d    = S_IDLE;
          ref_done_c = 1'b1;
        end else begin
          state_d = S_REF_WAIT;
          wait_d  = WAIT_W'(RFC_LOAD);
        end
      end
      S_REF_WAIT: begin
        if (wait_cnt == '0) begin
          state_d    = S_IDLE;
          ref_done_c = 1'b1;
        end else begin
          wait_d = wait_cnt - WAIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: the command the bus will carry in the state being entered.
  always_comb begin
    cmd_d      = CMD_NOP;
    cmd_addr_d = '0;
    cmd_data_d = '0;
    cmd_id_d   = '0;
    case (state_d)
      S_ACT: begin
        cmd_d      = CMD_ACT;
        cmd_addr_d = lat_addr_d;
        cmd_id_d   = lat_id_d;
      end
      S_RW: begin
        cmd_d      = lat_write_d ? CMD_WR : CMD_RD;
        cmd_addr_d = lat_addr_d;
        cmd_data_d = lat_write_d ? lat_data_d : 32'd0;
        cmd_id_d   = lat_id_d;
      end
      S_PRE: begin
        // Stalled PRE shows NOP until the row has been open for tRAS.
        if (tras_d == '0) begin
          cmd_d      = CMD_PRE;
          cmd_addr_d = {open_row, {COL_BITS{1'b0}}};
          cmd_id_d   = pre_ref_d ? 32'd0 : lat_id_d;
        end
      end
      S_REF: cmd_d = CMD_REF;
      default: ;
    endcase
  end

  // Datapath: request latch, row tracking, timing counters, refresh and command registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      global_cycle <= '0;
      lat_addr     <= '0;
      lat_data     <= '0;
      lat_id       <= '0;
      lat_write    <= 1'b0;
      row_open     <= 1'b0;
      open_row     <= '0;
      tras         <= '0;
      refi         <= REFI_W'(T_REFI);
      ref_pending  <= 1'b0;
      cmd_fire     <= 1'b0;
      {cs, ras, cas, we} <= CMD_NOP;
      cmd_addr     <= '0;
      cmd_data     <= '0;
      cmd_id       <= '0;
    end else begin
      global_cycle <= global_cycle + 64'd1;
      lat_addr     <= lat_addr_d;
      lat_data     <= lat_data_d;
      lat_id       <= lat_id_d;
      lat_write    <= lat_write_d;
      tras         <= tras_d;
      if (state == S_ACT) begin
        row_open <= 1'b1;
        open_row <= lat_addr[31:COL_BITS];
      end else if (pre_fire_c) begin
        row_open <= 1'b0;
      end
      if (state == S_REF)     refi <= REFI_W'(T_REFI);
      else if (refi != '0)    refi <= refi - REFI_W'(1);
      if (ref_done_c)         ref_pending <= 1'b0;
      else if (refi == '0)    ref_pending <= 1'b1;
      cmd_fire           <= (cmd_d != CMD_NOP);
      {cs, ras, cas, we} <= cmd_d;
      cmd_addr           <= cmd_addr_d;
      cmd_data           <= cmd_data_d;
      cmd_id             <= cmd_id_d;
    end
  end

endmodule

// File: tb/tb_bank_command_issuer.sv
// Bench for bank_command_issuer: directed scenarios plus random traffic, checked
// every cycle against a schedule predicted from the timing rules.
module tb_bank_command_issuer;

  localparam int COL_BITS = 10;
  localparam int T_RCD    = 3;
  localparam int T_RP     = 3;
  localparam int T_RAS    = 8;
  localparam int T_REFI   = 200;
  localparam int T_RFC    = 20;
  localparam int MAXC     = 8192;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_id = '0;
  logic        cmd_fire, cs, ras, cas, we;
  logic [31:0] cmd_addr, cmd_data, cmd_id;
  logic [63:0] global_cycle;

  always #5 clk = ~clk;

  bank_command_issuer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_write(req_write), .req_id(req_id),
    .cmd_fire(cmd_fire), .cs(cs), .ras(ras), .cas(cas), .we(we),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_id(cmd_id),
    .global_cycle(global_cycle)
  );

  // Expected bus contents per bench cycle (NOP unless a command is scheduled).
  logic [3:0]  exp_enc  [MAXC];
  logic [31:0] exp_addr [MAXC];
  logic [31:0] exp_data [MAXC];
  logic [31:0] exp_id   [MAXC];

  int compared = 0;
  int mismatched = 0;
  int t = 0;       // bench cycle index
  int t_r = 0;     // cycle in which reset was released

  // Reference model of the bank, expressed as absolute cycle times.
  int          m_free;      // first cycle the bank is idle again
  int          m_pend_at;   // first cycle refresh is pending
  int          m_act_at;
  bit          m_row_open;
  logic [21:0] m_row;

  // Bench-side request waiting to be accepted.
  bit          want = 1'b0;
  logic [31:0] w_addr, w_data, w_id;
  logic        w_wr;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic put(input int c, input logic [3:0] enc, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] id);
    if (c >= 0 && c < MAXC) begin
      exp_enc[c] = enc; exp_addr[c] = a; exp_data[c] = d; exp_id[c] = id;
    end
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      exp_enc[i] = 4'hF; exp_addr[i] = '0; exp_data[i] = '0; exp_id[i] = '0;
    end
  endtask

  task automatic model_refresh();
    int p;
    int r;
    if (t >= m_free && t >= m_pend_at) begin
      if (m_row_open) begin
        p = max2(t + 1, m_act_at + T_RAS);
        put(p, 4'b0010, 32'(m_row) << COL_BITS, 32'd0, 32'd0);
        r = p + T_RP;
      end else begin
        r = t + 1;
      end
      put(r, 4'b0001, 32'd0, 32'd0, 32'd0);
      m_free     = r + T_RFC;
      m_pend_at  = r + T_REFI + 2;
      m_row_open = 1'b0;
    end
  endtask

  task automatic model_accept();
    int          rw;
    int          p;
    int          a;
    logic [21:0] row;
    row = w_addr[31:COL_BITS];
    if (m_row_open && row == m_row) begin
      rw = t + 1;
    end else begin
      if (m_row_open) begin
        p = max2(t + 1, m_act_at + T_RAS);
        put(p, 4'b0010, 32'(m_row) << COL_BITS, 32'd0, w_id);
        a = p + T_RP;
      end else begin
        a = t + 1;
      end
      put(a, 4'b0011, w_addr, 32'd0, w_id);
      m_act_at   = a;
      m_row_open = 1'b1;
      m_row      = row;
      rw         = a + T_RCD;
    end
    put(rw, w_wr ? 4'b0100 : 4'b0101, w_addr, w_wr ? w_data : 32'd0, w_id);
    m_free = rw + 1;
  endtask

  // One cycle: model decision, drive, check, then advance to the next negedge.
  task automatic tick();
    bit rdy;
    model_refresh();
    rdy = (t >= m_free) && (t < m_pend_at);
    req_valid = want;
    req_addr  = w_addr;
    req_data  = w_data;
    req_write = w_wr;
    req_id    = w_id;
    #1;
    compared++;
    assert (global_cycle === 64'(t - t_r)) else begin
      mismatched++;
      $error("FAIL global_cycle t=%0d: observed %0d expected %0d", t, global_cycle, t - t_r);
    end
    compared++;
    assert (req_ready === rdy) else begin
      mismatched++;
      $error("FAIL req_ready t=%0d: observed %b expected %b", t, req_ready, rdy);
    end
    compared++;
    assert ({cmd_fire, cs, ras, cas, we} === {exp_enc[t] != 4'hF, exp_enc[t]}) else begin
      mismatched++;
      $error("FAIL cmd_enc t=%0d: observed fire=%b %b%b%b%b expected fire=%b %b",
             t, cmd_fire, cs, ras, cas, we, exp_enc[t] != 4'hF, exp_enc[t]);
    end
    compared++;
    assert ({cmd_addr, cmd_data, cmd_id} === {exp_addr[t], exp_data[t], exp_id[t]}) else begin
      mismatched++;
      $error("FAIL cmd_fields t=%0d: observed addr=%h data=%h id=%0d expected addr=%h data=%h id=%0d",
             t, cmd_addr, cmd_data, cmd_id, exp_addr[t], exp_data[t], exp_id[t]);
    end
    if (want && rdy) begin
      model_accept();
      want = 1'b0;
    end
    @(posedge clk);
    t++;
    @(negedge clk);
  endtask

  task automatic check_in_reset();
    #1;
    compared++;
    assert ({cmd_fire, cs, ras, cas, we, cmd_addr, cmd_data, cmd_id} === {1'b0, 4'hF, 96'd0}) else begin
      mismatched++;
      $error("FAIL reset_bus t=%0d: observed fire=%b %b%b%b%b addr=%h expected NOP/zero",
             t, cmd_fire, cs, ras, cas, we, cmd_addr);
    end
    compared++;
    assert ({req_ready, global_cycle} === {1'b0, 64'd0}) else begin
      mismatched++;
      $error("FAIL reset_ready_cycle t=%0d: observed ready=%b cycle=%0d expected 0/0",
             t, req_ready, global_cycle);
    end
  endtask

  // Assert reset at a negedge, hold it n cycles, release; the model restarts.
  task automatic reset_hold(input int n);
    want = 1'b0;
    req_valid = 1'b0;
    reset = 1'b0;
    clear_from(t);
    check_in_reset();
    repeat (n) begin
      @(posedge clk);
      t++;
      @(negedge clk);
      check_in_reset();
    end
    reset      = 1'b1;
    t_r        = t;
    m_free     = t;
    m_pend_at  = t + T_REFI + 1;
    m_row_open = 1'b0;
    m_act_at   = -1000;
  endtask

  task automatic idle_until_gc(input int gc);
    while (t - t_r < gc && t < MAXC - 2) tick();
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic wr,
                      input logic [31:0] id);
    w_addr = a; w_data = d; w_wr = wr; w_id = id;
    want = 1'b1;
    for (int i = 0; i < 400 && want; i++) tick();
    compared++;
    assert (want == 1'b0) else begin
      mismatched++;
      $error("FAIL accept_timeout addr=%h: observed not accepted expected accepted", a);
    end
    want = 1'b0;
  endtask

  logic [21:0] rows [4];

  initial begin
    int gap;
    logic [31:0] a;
    rows[0] = 22'd0; rows[1] = 22'd1; rows[2] = 22'h3FFFFF; rows[3] = 22'h2A5;
    w_addr = '0; w_data = '0; w_wr = 1'b0; w_id = '0;
    clear_from(0);
    @(negedge clk);
    reset_hold(3);

    // Closed row, open-row hit, open-row miss.
    idle_until_gc(10); send(32'h0000_0400, 32'd0, 1'b0, 32'd5);
    idle_until_gc(20); send(32'h0000_0404, 32'h0000_DEAD, 1'b1, 32'd6);
    idle_until_gc(30); send(32'h0000_0800, 32'd0, 1'b0, 32'd7);
    // Refresh with a row open, then a second refresh with the row closed.
    idle_until_gc(260);
    idle_until_gc(480);
    send(32'h0000_0400, 32'd0, 1'b0, 32'd8);
    // Miss right after a fresh ACT: PRE held back by tRAS.
    send(32'h0000_1000, 32'h1234_5678, 1'b1, 32'd9);
    // Reset during ACT_WAIT drops the request; same row must be reactivated.
    send(32'h0000_3000, 32'd0, 1'b0, 32'd10);
    while (t < m_act_at + 1 && t < MAXC - 2) tick();
    reset_hold(2);
    send(32'h0000_3004, 32'h0BAD_F00D, 1'b1, 32'd11);

    // Random traffic over a handful of rows, crossing several refreshes.
    for (int i = 0; i < 150 && t < MAXC - 200; i++) begin
      gap = int'($urandom_range(0, 4));
      a = (32'(rows[$urandom_range(0, 3)]) << COL_BITS) | (32'($urandom_range(0, 255)) << 2);
      send(a, $urandom, 1'($urandom_range(0, 1)), 32'(i + 100));
      repeat (gap) tick();
    end
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
